// File: rtl/riscv_mem_responder_if.sv
// Core-side memory bus for riscv_mem_responder: dmem load/store, imem fetch and console stream.
interface riscv_mem_responder_if;
    logic        dmem_write_in;
    logic [31:0] dmem_write_addr_in;
    logic [31:0] dmem_write_data_in;
    logic [7:0]  dmem_write_mask_in;
    logic        dmem_read_in;
    logic [31:0] dmem_read_addr_in;
    logic [31:0] dmem_read_data_out;
    logic [31:0] imem_read_addr_in;
    logic [31:0] imem_read_data_out;
    logic        console_valid_out;
    logic [7:0]  console_data_out;
    logic        console_ready_in;
    logic [7:0]  console_overflow_out;
    logic        range_error_out;

    modport master (
        output dmem_write_in, dmem_write_addr_in, dmem_write_data_in, dmem_write_mask_in,
        output dmem_read_in, dmem_read_addr_in, imem_read_addr_in, console_ready_in,
        input  dmem_read_data_out, imem_read_data_out, console_valid_out, console_data_out,
        input  console_overflow_out, range_error_out
    );

    modport slave (
        input  dmem_write_in, dmem_write_addr_in, dmem_write_data_in, dmem_write_mask_in,
        input  dmem_read_in, dmem_read_addr_in, imem_read_addr_in, console_ready_in,
        output dmem_read_data_out, imem_read_data_out, console_valid_out, console_data_out,
        output console_overflow_out, range_error_out
    );
endinterface

// File: rtl/riscv_mem_responder.sv
// Memory-side responder: one shared RAM serving imem (combinational) and dmem (1-cycle loads,
// byte-masked stores), plus a memory-mapped console that queues bytes into a small stream FIFO.
module riscv_mem_responder #(
    parameter int unsigned MEM_WORDS    = 16384,
    parameter logic [31:0] MEM_BASE     = 32'h0000_0000,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1122_3344,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input logic                  clk,
    input logic                  reset,
    riscv_mem_responder_if.slave bus
);
    localparam int unsigned   AW          = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned   PW          = $clog2(FIFO_DEPTH);
    localparam int unsigned   CW          = $clog2(FIFO_DEPTH + 1);
    localparam logic [32:0]   RAM_BYTES   = 33'(MEM_WORDS) << 2;
    localparam logic [31:0]   STATUS_ADDR = CONSOLE_ADDR + 32'd4;
    localparam logic [CW-1:0] FULL_CNT    = CW'(FIFO_DEPTH);

    logic [31:0]   r_mem [MEM_WORDS];
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_overflow;
    logic          r_range_err;
    logic [31:0]   r_rdata;

    logic [32:0]   w_wa_off, w_ra_off, w_ia_off;
    logic          w_wr_ram, w_wr_con, w_wr_stat, w_wr_miss;
    logic          w_rd_ram, w_rd_con, w_rd_stat, w_rd_miss;
    logic          w_if_ram;
    logic [AW-1:0] w_wr_idx, w_rd_idx, w_if_idx;
    logic          w_full, w_empty, w_push_req, w_push, w_pop, w_drop;
    logic [31:0]   w_rd_word;
    logic          w_unused_mask;

    // Offsets are taken in 33 bits so an address below MEM_BASE wraps to a huge value and misses.
    assign w_wa_off  = {1'b0, bus.dmem_write_addr_in} - {1'b0, MEM_BASE};
    assign w_ra_off  = {1'b0, bus.dmem_read_addr_in}  - {1'b0, MEM_BASE};
    assign w_ia_off  = {1'b0, bus.imem_read_addr_in}  - {1'b0, MEM_BASE};
    assign w_wr_ram  = w_wa_off < RAM_BYTES;
    assign w_rd_ram  = w_ra_off < RAM_BYTES;
    assign w_if_ram  = w_ia_off < RAM_BYTES;
    assign w_wr_idx  = w_wa_off[AW+1:2];
    assign w_rd_idx  = w_ra_off[AW+1:2];
    assign w_if_idx  = w_ia_off[AW+1:2];

    assign w_wr_con  = !w_wr_ram && (bus.dmem_write_addr_in == CONSOLE_ADDR);
    assign w_wr_stat = !w_wr_ram && (bus.dmem_write_addr_in == STATUS_ADDR);
    assign w_wr_miss = bus.dmem_write_in && !w_wr_ram && !w_wr_con && !w_wr_stat;
    assign w_rd_con  = !w_rd_ram && (bus.dmem_read_addr_in == CONSOLE_ADDR);
    assign w_rd_stat = !w_rd_ram && (bus.dmem_read_addr_in == STATUS_ADDR);
    assign w_rd_miss = bus.dmem_read_in && !w_rd_ram && !w_rd_con && !w_rd_stat;
    assign w_unused_mask = ^bus.dmem_write_mask_in[7:4];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_pop      = !w_empty && bus.console_ready_in;
    assign w_push_req = bus.dmem_write_in && w_wr_con && bus.dmem_write_mask_in[0];
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    always_comb begin
        w_rd_word = '0;
        if (w_rd_ram)
            w_rd_word = r_mem[w_rd_idx];
        else if (w_rd_stat)
            w_rd_word = {16'b0, r_overflow, 4'b0, w_full, w_empty, r_count[1:0]};
    end

    always_ff @(posedge clk) begin
        if (bus.dmem_write_in && w_wr_ram) begin
            for (int i = 0; i < 4; i++)
                if (bus.dmem_write_mask_in[i])
                    r_mem[w_wr_idx][8*i +: 8] <= bus.dmem_write_data_in[8*i +: 8];
        end
        if (w_push)
            r_fifo[r_wr_ptr] <= bus.dmem_write_data_in[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= '0;
            r_range_err <= 1'b0;
            r_rdata     <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_overflow != 8'hFF))
                r_overflow <= r_overflow + 8'd1;
            if (w_wr_miss || w_rd_miss || !w_if_ram)
                r_range_err <= 1'b1;
            if (bus.dmem_read_in)
                r_rdata <= w_rd_word;
        end
    end

    assign bus.dmem_read_data_out   = r_rdata;
    assign bus.imem_read_data_out   = w_if_ram ? r_mem[w_if_idx] : 32'h0000_0013;
    assign bus.console_valid_out    = !w_empty;
    assign bus.console_data_out     = r_fifo[r_rd_ptr];
    assign bus.console_overflow_out = r_overflow;
    assign bus.range_error_out      = r_range_err;
endmodule

// File: doc/riscv_mem_responder.md
Name: riscv_mem_responder

Overview:
- Memory-side responder for the RiscV core's dmem and imem ports.
- Holds one shared word-addressed RAM: imem reads are combinational, dmem reads have 1-cycle latency, and dmem writes are byte-masked.
- Decodes a memory-mapped console at CONSOLE_ADDR. Console writes feed a byte FIFO that drains over a valid/ready stream to the testbench or UART.

Parameters:
MEM_WORDS, 16384, RAM depth in 32-bit words (64 KiB)
MEM_BASE, 0, byte address of RAM word 0
CONSOLE_ADDR, 287454020 (0x11223344), console data register byte address
FIFO_DEPTH, 8, console FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
dmem_write_in  in  1  store strobe from core
dmem_write_addr_in  in  32  store byte address
dmem_write_data_in  in  32  store data
dmem_write_mask_in  in  8  byte enables; bits [3:0] used, [7:4] ignored
dmem_read_in  in  1  load strobe
dmem_read_addr_in  in  32  load byte address
dmem_read_data_out  out  32  load data, valid the cycle after dmem_read_in
imem_read_addr_in  in  32  fetch byte address (core pc)
imem_read_data_out  out  32  fetch data, combinational
console_valid_out  out  1  FIFO head valid
console_data_out  out  8  FIFO head byte
console_ready_in  in  1  sink accepts head byte
console_overflow_out  out  8  count of dropped console bytes, saturating
range_error_out  out  1  sticky flag: access outside RAM and console space

Behaviour:
- Reset (reset=0, asynchronous):
  - dmem_read_data_out=0, FIFO pointers and count=0, console_valid_out=0, console_overflow_out=0, range_error_out=0.
  - RAM contents are not reset.
  - Reset asserted mid-operation discards FIFO contents immediately.
- Decode, with wa = dmem_write_addr_in and ra = dmem_read_addr_in:
  - RAM hit: MEM_BASE <= addr < MEM_BASE+4*MEM_WORDS. Index = (addr-MEM_BASE)>>2; addr[1:0] is ignored.
  - CONSOLE_ADDR is the console data register. CONSOLE_ADDR+4 is the console status register (read-only).
  - Any other address is a miss.
- Stores (dmem_write_in=1):
  - RAM hit: byte i of the word is written at the clock edge when mask[i]=1.
  - CONSOLE_ADDR with mask[0]=1: push data[7:0] into the FIFO. A mask[0]=0 console write is ignored.
  - Store to the status register is ignored.
  - Miss: no write and range_error_out<=1.
- Loads (dmem_read_in=1) are registered, with data on dmem_read_data_out the next cycle:
  - RAM hit: word value before any same-cycle store (read-first).
  - CONSOLE_ADDR: returns 0.
  - Status register: {16'b0, overflow[7:0], 4'b0, full, empty, count[1:0]} truncated; count is the entry count modulo 4. Full and empty reflect state before same-cycle push/pop.
  - Miss: 0, and range_error_out<=1.
  - When dmem_read_in=0, dmem_read_data_out holds its previous value.
- imem: imem_read_data_out = RAM[(imem_read_addr_in-MEM_BASE)>>2] combinationally.
  - Out-of-range fetch returns 0x00000013 (NOP) and sets range_error_out.
  - A store to the fetched word becomes visible on imem after the write edge.
- Console FIFO:
  - Circular buffer with wrapping read/write pointers and an occupancy counter 0..FIFO_DEPTH.
  - console_valid_out = (count != 0); console_data_out = head entry.
  - Pop when console_valid_out & console_ready_in.
  - Push when full without a same-cycle pop: byte dropped, overflow increments and saturates at 255.
  - Push and pop in the same cycle are both performed and count is unchanged; this applies when full as well, so no drop.
  - Push and pop in the same cycle when empty: the push succeeds and the pop does not occur (valid=0 that cycle).
- Store and load in the same cycle to different or the same addresses are independent; load follows the read-first rule.
- range_error_out clears only on reset.

Test Plan:
- Store 0xDEADBEEF to byte address 0x100 with mask 0xF, then load 0x100 -> dmem_read_data_out=0xDEADBEEF one cycle after the load. imem_read_addr_in=0x100 gives 0xDEADBEEF.
- Store 0x000000AA to 0x100 with mask 0x1 over 0xDEADBEEF, then load -> 0xDEADBEAA. Same-cycle store+load to 0x100 -> the load returns the old value.
- Write 'H','i' (0x48, 0x69) to CONSOLE_ADDR with console_ready_in=1 -> console_data_out presents 0x48 then 0x69 on consecutive valid cycles; valid drops after.
- With ready=0, write 10 bytes 0x30..0x39 into the depth-8 FIFO -> overflow=2. Then drain -> 0x30..0x37 in order. Status read before drain shows full=1.
- With a full FIFO, push and pop in the same cycle -> no drop, overflow unchanged, count stays 8. Pointer wrap is exercised over 20 pushes/pops with order preserved.
- Load from 0x80000000 -> data 0 and range_error_out=1. Assert reset mid-drain -> console_valid_out=0, overflow=0, range_error_out=0 immediately.
